// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, port count.
package alu_seq_pkg;

   localparam int NPORTS = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_EOR = 3'd3;
   localparam logic [2:0] OP_ORA = 3'd4;
   localparam logic [2:0] OP_LSR = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC_LO = 2'd1,
      EXEC_HI = 2'd2,
      RSP     = 2'd3
   } state_t;

   // Opcodes 6 and 7 have no ALU pass and return an error response.
   function automatic logic op_reserved(input logic [2:0] op);
      return op > OP_LSR;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the port not granted last wins a tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       id
);

   logic last;

   // Grant at most one requester while enabled, favouring the one not served last.
   always_comb begin
      grant = 2'b00;
      id    = 1'b0;
      if (en) begin
         if (req[0] && (!req[1] || last)) begin
            grant = 2'b01;
            id    = 1'b0;
         end else if (req[1]) begin
            grant = 2'b10;
            id    = 1'b1;
         end
      end
   end

   // Remember the last granted port; reset makes port 0 the first winner.
   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (|grant)
         last <= id;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer in front of the cpu6502 ALU: arbitrates two requesters, runs one
// or two byte passes through the ALU and returns the result by valid/ready.
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_req_valid,
   output logic [1:0]  o_req_ready,
   input  logic [5:0]  i_req_op,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   input  logic [1:0]  i_req_wide,
   input  logic [1:0]  i_req_cin,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_id,
   output logic [15:0] o_rsp_data,
   output logic        o_rsp_carry,
   output logic        o_rsp_err,
   output logic [7:0]  o_sb,
   output logic [7:0]  o_db,
   output logic        o_sb_add,
   output logic        o_db_add,
   output logic        o_db_n_add,
   output logic        o_0_add,
   output logic        o_1_addc,
   output logic        o_sums,
   output logic        o_ands,
   output logic        o_eors,
   output logic        o_ors,
   output logic        o_srs,
   input  logic [7:0]  i_alu_add,
   input  logic        i_alu_acr
);

   state_t      state, state_nxt;
   logic [1:0]  grant;
   logic        gnt_id;
   logic        arb_en;
   logic        accept;

   logic [2:0]  req_op;
   logic [15:0] req_a, req_b;
   logic        req_wide, req_cin;

   // Request captured on the accept edge.
   logic [2:0]  op_p0;
   logic [15:0] a_p0, b_p0;
   logic        wide_p0, cin_p0, id_p0;

   // Pass results; carry_p1 is both the inter-pass carry and the final carry.
   logic [7:0]  res_lo_p1, res_hi_p1;
   logic        carry_p1, err_p1;

   logic        hi_pass, exec;
   logic [7:0]  a_byte, b_byte, b_eff;
   logic        cin_pass, pass_carry, lsr_merge;

   assign arb_en = (state == IDLE) && !i_reset;
   assign accept = |grant;

   rr_arbiter2 u_arb (
      .clk   (i_clk),
      .rst   (i_reset),
      .en    (arb_en),
      .req   (i_req_valid),
      .grant (grant),
      .id    (gnt_id)
   );

   assign o_req_ready = grant;

   assign req_op   = gnt_id ? i_req_op[5:3]    : i_req_op[2:0];
   assign req_a    = gnt_id ? i_req_a[31:16]   : i_req_a[15:0];
   assign req_b    = gnt_id ? i_req_b[31:16]   : i_req_b[15:0];
   assign req_wide = gnt_id ? i_req_wide[1]    : i_req_wide[0];
   assign req_cin  = gnt_id ? i_req_cin[1]     : i_req_cin[0];

   assign hi_pass   = (state == EXEC_HI);
   assign exec      = (state == EXEC_LO) || hi_pass;
   assign a_byte    = hi_pass ? a_p0[15:8] : a_p0[7:0];
   assign b_byte    = hi_pass ? b_p0[15:8] : b_p0[7:0];
   assign b_eff     = (op_p0 == OP_SUB) ? ~b_byte : b_byte;
   assign cin_pass  = hi_pass ? carry_p1 : cin_p0;
   assign lsr_merge = (op_p0 == OP_LSR) && wide_p0 && carry_p1;

   // Carry of the current pass: local 9-bit sum for ADD/SUB, ALU carry for LSR.
   always_comb begin
      pass_carry = 1'b0;
      if (op_p0 == OP_ADD || op_p0 == OP_SUB)
         pass_carry = ({1'b0, a_byte} + {1'b0, b_eff} + {8'd0, cin_pass}) > 9'd255;
      else if (op_p0 == OP_LSR)
         pass_carry = i_alu_acr;
   end

   // State register; reset returns to IDLE from anywhere.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus ALU strobes and byte buses, all zero outside EXEC.
   always_comb begin
      state_nxt  = state;
      o_sb       = 8'd0;
      o_db       = 8'd0;
      o_sb_add   = 1'b0;
      o_db_add   = 1'b0;
      o_db_n_add = 1'b0;
      o_0_add    = 1'b0;
      o_1_addc   = 1'b0;
      o_sums     = 1'b0;
      o_ands     = 1'b0;
      o_eors     = 1'b0;
      o_ors      = 1'b0;
      o_srs      = 1'b0;

      if (exec) begin
         o_sb     = a_byte;
         o_sb_add = 1'b1;
         case (op_p0)
            OP_ADD: begin o_db = b_byte; o_db_add = 1'b1;   o_sums = 1'b1; o_1_addc = cin_pass; end
            OP_SUB: begin o_db = b_byte; o_db_n_add = 1'b1; o_sums = 1'b1; o_1_addc = cin_pass; end
            OP_AND: begin o_db = b_byte; o_db_add = 1'b1;   o_ands = 1'b1; end
            OP_EOR: begin o_db = b_byte; o_db_add = 1'b1;   o_eors = 1'b1; end
            OP_ORA: begin o_db = b_byte; o_db_add = 1'b1;   o_ors  = 1'b1; end
            OP_LSR: begin o_srs = 1'b1; end
            default: ;
         endcase
      end

      case (state)
         IDLE: begin
            if (accept) begin
               if (op_reserved(req_op))
                  state_nxt = RSP;
               else if (req_op == OP_LSR && req_wide)
                  state_nxt = EXEC_HI;
               else
                  state_nxt = EXEC_LO;
            end
         end
         EXEC_LO: state_nxt = (wide_p0 && op_p0 != OP_LSR) ? EXEC_HI : RSP;
         EXEC_HI: state_nxt = (op_p0 == OP_LSR) ? EXEC_LO : RSP;
         RSP:     if (i_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture on accept, then per-pass capture of the ALU hold register.
   always_ff @(posedge i_clk) begin
      if (state == IDLE && accept) begin
         op_p0     <= req_op;
         a_p0      <= req_a;
         b_p0      <= req_b;
         wide_p0   <= req_wide;
         cin_p0    <= req_cin;
         id_p0     <= gnt_id;
         res_lo_p1 <= 8'd0;
         res_hi_p1 <= 8'd0;
         carry_p1  <= 1'b0;
         err_p1    <= op_reserved(req_op);
      end else if (state == EXEC_LO) begin
         res_lo_p1 <= i_alu_add | {lsr_merge, 7'd0};
         carry_p1  <= pass_carry;
      end else if (state == EXEC_HI) begin
         res_hi_p1 <= i_alu_add;
         carry_p1  <= pass_carry;
      end
   end

   // Response is only presented in RSP; everything reads zero elsewhere.
   assign o_rsp_valid = (state == RSP);
   assign o_rsp_id    = o_rsp_valid & id_p0;
   assign o_rsp_data  = o_rsp_valid ? {res_hi_p1, res_lo_p1} : 16'd0;
   assign o_rsp_carry = o_rsp_valid & carry_p1;
   assign o_rsp_err   = o_rsp_valid & err_p1;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU on the falling edge.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [1:0]  i_req_valid;
   logic [1:0]  o_req_ready;
   logic [5:0]  i_req_op;
   logic [31:0] i_req_a, i_req_b;
   logic [1:0]  i_req_wide, i_req_cin;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_carry, o_rsp_err;
   logic [15:0] o_rsp_data;
   logic [7:0]  o_sb, o_db;
   logic        o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc;
   logic        o_sums, o_ands, o_eors, o_ors, o_srs;
   logic [7:0]  alu_add = 8'd0;
   logic        alu_acr;

   alu_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
      .i_req_wide(i_req_wide), .i_req_cin(i_req_cin),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
      .o_rsp_data(o_rsp_data), .o_rsp_carry(o_rsp_carry), .o_rsp_err(o_rsp_err),
      .o_sb(o_sb), .o_db(o_db), .o_sb_add(o_sb_add), .o_db_add(o_db_add),
      .o_db_n_add(o_db_n_add), .o_0_add(o_0_add), .o_1_addc(o_1_addc),
      .o_sums(o_sums), .o_ands(o_ands), .o_eors(o_eors), .o_ors(o_ors), .o_srs(o_srs),
      .i_alu_add(alu_add), .i_alu_acr(alu_acr)
   );

   always #5 i_clk = ~i_clk;

   // ALU model: hold register latches on the falling edge, carry is combinational.
   always @(negedge i_clk) begin
      if (o_sums)      alu_add <= o_sb + (o_db_n_add ? ~o_db : o_db) + {7'd0, o_1_addc};
      else if (o_ands) alu_add <= o_sb & o_db;
      else if (o_eors) alu_add <= o_sb ^ o_db;
      else if (o_ors)  alu_add <= o_sb | o_db;
      else if (o_srs)  alu_add <= {1'b0, o_sb[7:1]};
   end

   always_comb begin
      logic [8:0] s;
      s = {1'b0, o_sb} + {1'b0, (o_db_n_add ? ~o_db : o_db)} + {8'd0, o_1_addc};
      alu_acr = o_srs ? o_sb[0] : (o_sums ? s[8] : 1'b0);
   end

   wire [25:0] alu_bus = {o_sb, o_db, o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc,
                          o_sums, o_ands, o_eors, o_ors, o_srs};

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        carry;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0, bad = 0, cyc = 0, rsp_cnt = 0, issued = 0;
   logic both_ready = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;
   always @(negedge i_clk) if (o_req_ready == 2'b11) both_ready <= 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, expv);
      end
   endtask

   task automatic push_exp(input int p, input logic [15:0] d, input logic c, input logic e,
                           input int lat);
      exp_t x;
      x.id = p; x.data = d; x.carry = c; x.err = e; x.lat = lat; x.acc = cyc + 1;
      exp_q.push_back(x);
      issued++;
   endtask

   // Present a request on port p; returns at the falling edge after the accept edge.
   task automatic issue(input int p, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic wide, input logic cin,
                        input logic [15:0] ed, input logic ec, input logic ee, input int lat);
      int n;
      @(negedge i_clk);
      i_req_op[3*p +: 3] = op;
      i_req_a[16*p +: 16] = a;
      i_req_b[16*p +: 16] = b;
      i_req_wide[p] = wide;
      i_req_cin[p] = cin;
      i_req_valid[p] = 1'b1;
      #1;
      n = 0;
      while (!o_req_ready[p] && n < 50) begin
         @(negedge i_clk); #1; n++;
      end
      if (!o_req_ready[p]) begin
         chk("req_ready_timeout", {31'd0, o_req_ready[p]}, 32'd1);
         i_req_valid[p] = 1'b0;
      end else begin
         push_exp(p, ed, ec, ee, lat);
         @(negedge i_clk);
         i_req_valid[p] = 1'b0;
         i_req_a[16*p +: 16] = 16'hA5A5;
         i_req_b[16*p +: 16] = 16'h5A5A;
      end
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (rsp_cnt < issued && n < 100) begin
         @(negedge i_clk); n++;
      end
      if (rsp_cnt < issued) chk("rsp_timeout", rsp_cnt, issued);
   endtask

   // Monitor: pops the scoreboard on every response handshake.
   initial begin : monitor
      int   first;
      bit   seen;
      exp_t e;
      seen = 0; first = 0;
      forever begin
         @(negedge i_clk); #1;
         if (o_rsp_valid && !seen) begin seen = 1; first = cyc; end
         if (o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp_unexpected got=%0h want=none", o_rsp_data);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", {31'd0, o_rsp_id}, e.id);
               chk("rsp_data", {16'd0, o_rsp_data}, {16'd0, e.data});
               chk("rsp_carry", {31'd0, o_rsp_carry}, {31'd0, e.carry});
               chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
               chk("rsp_latency", first - e.acc + 1, e.lat);
            end
            seen = 0;
            rsp_cnt++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b1; i_req_valid = 2'b00; i_req_op = '0; i_req_a = '0; i_req_b = '0;
      i_req_wide = '0; i_req_cin = '0; i_rsp_ready = 1'b1;
      repeat (3) @(negedge i_clk);
      #1;
      chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 0);
      chk("reset_ready", {30'd0, o_req_ready}, 0);
      chk("reset_alu_bus", {6'd0, alu_bus}, 0);
      @(negedge i_clk);
      i_reset = 1'b0;

      // 8-bit ADD with carry in
      issue(0, OP_ADD, 16'h0070, 16'h0090, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 2);
      chk("add_sb", {24'd0, o_sb}, 32'h70);
      chk("add_db", {24'd0, o_db}, 32'h90);
      chk("add_strobes", {27'd0, o_db_add, o_db_n_add, o_sums, o_1_addc, o_0_add}, 32'b10110);
      wait_rsp();

      // 16-bit SUB: inverted B on both passes, carry chained low to high
      issue(1, OP_SUB, 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0, 3);
      chk("sub_lo_dbn", {30'd0, o_db_n_add, o_db_add}, 32'b10);
      chk("sub_lo_addc", {31'd0, o_1_addc}, 1);
      chk("sub_lo_sb", {24'd0, o_sb}, 32'h00);
      @(negedge i_clk);
      chk("sub_hi_dbn", {30'd0, o_db_n_add, o_db_add}, 32'b10);
      chk("sub_hi_addc", {31'd0, o_1_addc}, 0);
      chk("sub_hi_sb", {24'd0, o_sb}, 32'h10);
      wait_rsp();

      // 16-bit LSR: high byte first, shifted-out bit into low bit 7
      issue(0, OP_LSR, 16'h0181, 16'h0000, 1'b1, 1'b0, 16'h00C0, 1'b1, 1'b0, 3);
      chk("lsr_first_sb", {24'd0, o_sb}, 32'h01);
      chk("lsr_first_srs", {31'd0, o_srs}, 1);
      @(negedge i_clk);
      chk("lsr_second_sb", {24'd0, o_sb}, 32'h81);
      wait_rsp();

      // Further directed vectors: carry ripple, logic ops with junk high bytes, 8-bit LSR
      issue(1, OP_ADD, 16'h12FF, 16'h0001, 1'b1, 1'b0, 16'h1300, 1'b0, 1'b0, 3);
      wait_rsp();
      issue(0, OP_AND, 16'h55F0, 16'hAA3C, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 2);
      wait_rsp();
      issue(1, OP_LSR, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 2);
      wait_rsp();
      issue(0, OP_ORA, 16'h00A0, 16'h0005, 1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, 2);
      wait_rsp();

      // Response back-pressure for 5 cycles with another request pending
      i_rsp_ready = 1'b0;
      issue(1, OP_EOR, 16'h0055, 16'h00FF, 1'b0, 1'b0, 16'h00AA, 1'b0, 1'b0, 2);
      @(negedge i_clk);
      i_req_op[2:0] = OP_ADD;
      i_req_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_valid", {31'd0, o_rsp_valid}, 1);
         chk("stall_data", {16'd0, o_rsp_data}, 32'h00AA);
         chk("stall_ready", {30'd0, o_req_ready}, 0);
         chk("stall_alu_bus", {6'd0, alu_bus}, 0);
         @(negedge i_clk);
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      #1;
      chk("post_hs_valid", {31'd0, o_rsp_valid}, 0);
      chk("post_hs_ready", {30'd0, o_req_ready}, 32'b01);
      i_req_valid = 2'b00;
      wait_rsp();

      // Round robin with both ports continuously valid after reset
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      i_req_op = {OP_EOR, OP_ADD};
      i_req_a = {16'h00FF, 16'h0011};
      i_req_b = {16'h000F, 16'h0022};
      i_req_wide = 2'b00;
      i_req_cin = 2'b00;
      i_req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int n;
         n = 0;
         #1;
         while (o_req_ready == 2'b00 && n < 50) begin
            @(negedge i_clk); #1; n++;
         end
         chk("rr_grant", {30'd0, o_req_ready}, (i % 2) ? 32'b10 : 32'b01);
         if (i % 2) push_exp(1, 16'h00F0, 1'b0, 1'b0, 2);
         else       push_exp(0, 16'h0033, 1'b0, 1'b0, 2);
         @(negedge i_clk);
      end
      i_req_valid = 2'b00;
      wait_rsp();

      // Reset during the high pass of a 16-bit ADD
      issue(1, OP_ADD, 16'h0101, 16'h0101, 1'b1, 1'b0, 16'h0202, 1'b0, 1'b0, 3);
      @(negedge i_clk);
      #1;
      chk("hi_pass_sums", {31'd0, o_sums}, 1);
      i_reset = 1'b1;
      @(negedge i_clk);
      #1;
      chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 0);
      chk("rst_ready", {30'd0, o_req_ready}, 0);
      chk("rst_alu_bus", {6'd0, alu_bus}, 0);
      chk("rst_rsp_fields", {13'd0, o_rsp_data, o_rsp_carry, o_rsp_err, o_rsp_id}, 0);
      void'(exp_q.pop_back());
      issued--;
      i_req_valid = 2'b11;
      #1;
      chk("rst_held_ready", {30'd0, o_req_ready}, 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      chk("rst_first_grant", {30'd0, o_req_ready}, 32'b01);
      i_req_valid = 2'b00;

      // Reserved opcode: straight to an error response
      issue(0, 3'd6, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
      chk("rsvd_no_exec", {6'd0, alu_bus}, 0);
      wait_rsp();

      repeat (2) @(negedge i_clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("never_both_ready", {31'd0, both_ready}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencer and two-port arbiter in front of the cpu6502 ALU datapath. It accepts 8-bit or 16-bit operation requests from two requesters, grants them round-robin, and drives the ALU input-register and operation strobes for one or two byte passes. It captures the ALU result and carry and returns a response through a valid/ready handshake. Port 0 is the instruction-execute path; port 1 is the address-calculation path.

## Interface
- No parameters.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_req_valid  in  2  request valid, one bit per port.
- o_req_ready  out  2  request ready, one bit per port; at most one bit high.
- i_req_op  in  6  3-bit opcode per port; port p uses bits [3p+2:3p].
- i_req_a  in  32  16-bit A operand per port; port p uses [16p+15:16p].
- i_req_b  in  32  16-bit B operand per port.
- i_req_wide  in  2  1 selects a 16-bit operation, 0 selects 8-bit.
- i_req_cin  in  2  carry in for ADD/SUB.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accepted.
- o_rsp_id  out  1  port that issued the request.
- o_rsp_data  out  16  result; bits [15:8] are 0 for 8-bit operations.
- o_rsp_carry  out  1  final carry out.
- o_rsp_err  out  1  reserved opcode was received.
- o_sb, o_db  out  8 each  ALU A and B byte operands.
- o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc  out  1 each  ALU input-register strobes.
- o_sums, o_ands, o_eors, o_ors, o_srs  out  1 each  ALU operation strobes.
- i_alu_add  in  8  ALU hold register output; it latches on the falling edge of i_clk.
- i_alu_acr  in  1  ALU carry output.

## Operation
- Opcodes:
  - 0 ADD: A + B + cin
  - 1 SUB: A + ~B + cin
  - 2 AND
  - 3 EOR
  - 4 ORA
  - 5 LSR: operates on A; B is ignored.
  - 6 and 7 are reserved.
- States: IDLE, EXEC_LO, EXEC_HI, RSP.
- IDLE:
  - The arbiter selects one port with valid high and raises only that port's ready.
  - When both ports are valid, the port not granted last wins. After reset, port 0 has priority.
  - On the accepting edge, the sequencer registers op, A, B, wide, cin and id.
- First and second pass:
  - ADD, SUB and logic ops: EXEC_LO handles the low byte, then EXEC_HI if wide.
  - LSR: the high byte is processed first, in EXEC_HI, then EXEC_LO. The shifted-out bit of the high byte is ORed into bit 7 of the low result.
- In an EXEC state:
  - o_sb carries the A byte and o_sb_add=1.
  - For ADD and logic ops, o_db carries the B byte and o_db_add=1. For SUB, o_db_n_add=1 instead.
  - Exactly one operation strobe is high.
  - o_1_addc=cin for the first pass of ADD/SUB and equals the low-byte carry on the high pass.
  - o_0_add is always 0.
- Carry:
  - ADD/SUB carry is bit 8 of the 9-bit sum of the driven byte operands, computed locally.
  - LSR carry is i_alu_acr.
  - Logic ops give carry 0.
- Reserved opcode: no EXEC state runs. The block goes directly to RSP with data 0, carry 0 and err 1.
- RSP: the response is held stable until i_rsp_ready=1, then the block returns to IDLE. Ready stays 0 for the whole time the block is out of IDLE.
- Reset, from any state:
  - State returns to IDLE and the round-robin pointer is reset.
  - All outputs go to 0, including buses, strobes, ready and rsp_valid.

## Timing
- Outside the EXEC states, all ALU strobes and the o_sb/o_db buses are 0.
- Each EXEC state lasts one cycle. Results are captured on the rising edge that ends it: i_alu_add was latched mid-cycle on the falling edge, and i_alu_acr is combinational.
- Latency is counted from the accept edge T:
  - 8-bit operation: o_rsp_valid high from cycle T+2.
  - 16-bit operation: o_rsp_valid high from cycle T+3.
  - Reserved opcode: o_rsp_valid high from cycle T+1.
- The earliest next accept is the edge following the response handshake edge; there is no bypass.
- Request operands only need to be valid on the accept edge.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode constants OP_ADD..OP_LSR
  - the state enum
  - the port-count constant (2)
- Sub-module rr_arbiter2 contains the two-request round-robin arbiter with grant/last-grant pointer. It is instantiated once.
- Everything else (FSM, operand byte muxing, carry chain, result assembly) lives in alu_sequencer.

## Test plan
- Port 0, 8-bit ADD, A=0x0070, B=0x0090, cin=1 -> rsp data 0x0001, carry 1, id 0, err 0, valid at T+2.
- Port 1, 16-bit SUB, A=0x1000, B=0x0001, cin=1 -> data 0x0FFF, carry 1. o_db_n_add is high in both EXEC cycles; o_1_addc is 1 on the low pass and 0 on the high pass.
- 16-bit LSR, A=0x0181 -> data 0x00C0, carry 1. The high byte (o_sb=0x01) is driven first, then the low byte (0x81).
- Both ports hold valid continuously after reset -> grants go 0,1,0,1; ready is never high on both ports.
- i_rsp_ready=0 for 5 cycles -> response stable, o_req_ready=0, all ALU strobes 0. The handshake then completes and IDLE follows.
- i_reset=1 during EXEC_HI -> all outputs 0 on the next cycle and port 0 is granted first afterwards. Separately, opcode 6 -> data 0, carry 0, err 1, valid at T+1.
